// File: rtl/theta_slice_engine_if.sv
// Slice-memory bus between the theta engine and its input/output slice memories.
// The engine is the master: it drives the read request and the write strobe,
// and the input memory returns read data one cycle after the request.
interface theta_slice_engine_if #(
  parameter int N      = 25,
  parameter int ADDR_W = 6
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/theta_slice_engine.sv
// Sequential theta step over a 5x5xDEPTH state, one 25-bit depth slice per cycle.
// Slice DEPTH-1 is prefetched first so the z=0 slice sees its wrapped neighbour;
// the previous slice is held in prev_q and feeds the x+1 column parity term.
//
// state | meaning
// IDLE  | waiting for start_i, all strobes low
// PRE   | request slice DEPTH-1 (wrap neighbour of z=0)
// LOAD  | latch slice DEPTH-1 into prev_q, request slice 0
// RUN   | write theta(slice z, slice z-1), request slice z+1
// DONE  | one-cycle done pulse, back to IDLE
module theta_slice_engine #(
  parameter int N      = 25,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  theta_slice_engine_if.master   mem
);

  typedef enum logic [2:0] {IDLE, PRE, LOAD, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_Z = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] z_q, z_d;
  logic [N-1:0]      prev_q, prev_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;

  // Bit (x,y) lives at index N-1-(x+5y); column x parity is the XOR over y.
  function automatic logic [4:0] col_parity(input logic [N-1:0] s);
    logic [4:0] c;
    c = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        c[x] = c[x] ^ s[N-1-(x+5*y)];
      end
    end
    return c;
  endfunction

  // out(x,y) = in(x,y) ^ C(x-1, cur) ^ C(x+1, prev), x wrapping mod 5.
  function automatic logic [N-1:0] theta(input logic [N-1:0] cur, input logic [N-1:0] prv);
    logic [4:0]   c_cur;
    logic [4:0]   c_prv;
    logic [N-1:0] o;
    c_cur = col_parity(cur);
    c_prv = col_parity(prv);
    o = cur;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        o[N-1-(x+5*y)] = cur[N-1-(x+5*y)] ^ c_cur[(x+4)%5] ^ c_prv[(x+1)%5];
      end
    end
    return o;
  endfunction

  // State, slice counter and previous-slice register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      z_q     <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      prev_q  <= prev_d;
    end
  end

  // Next state and strobes; memory strobes decode purely from state, z and data.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    prev_d  = prev_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = PRE;
      end
      PRE: begin
        busy_o  = 1'b1;
        rd_en   = 1'b1;
        rd_addr = LAST_Z;
        state_d = LOAD;
      end
      LOAD: begin
        busy_o  = 1'b1;
        prev_d  = mem.rd_data;
        rd_en   = 1'b1;
        rd_addr = '0;
        z_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        busy_o  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = z_q;
        wr_data = theta(mem.rd_data, prev_q);
        prev_d  = mem.rd_data;
        if (z_q == LAST_Z) begin
          state_d = DONE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = z_q + 1'b1;
          z_d     = z_q + 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.rd_en   = rd_en;
  assign mem.rd_addr = rd_addr;
  assign mem.wr_en   = wr_en;
  assign mem.wr_addr = wr_addr;
  assign mem.wr_data = wr_data;

endmodule

// File: tb/tb_theta_slice_engine.sv
// Directed bench for theta_slice_engine: input slice memory model with one-cycle
// read latency, write/done/read logging on the falling edge, golden theta model.
module tb_theta_slice_engine;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  theta_slice_engine_if #(.N(25), .ADDR_W(6)) mif ();

  theta_slice_engine #(.N(25), .DEPTH(64), .ADDR_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .mem    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] mem_in  [64];
  logic [24:0] out_mem [64];
  int          edge_cnt = 0;
  int          wr_count, done_count, first_wr_edge, last_wr_edge, done_edge, start_edge;
  bit          order_ok;
  int          rd_seq[$];
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    if (mif.rd_en) mif.rd_data <= mem_in[mif.rd_addr];
  end

  always @(negedge clk) begin
    if (mif.wr_en) begin
      if (int'(mif.wr_addr) != wr_count) order_ok = 1'b0;
      out_mem[mif.wr_addr] = mif.wr_data;
      if (wr_count == 0) first_wr_edge = edge_cnt + 1;
      last_wr_edge = edge_cnt + 1;
      wr_count++;
    end
    if (done) begin
      done_count++;
      done_edge = edge_cnt + 1;
    end
    if (mif.rd_en) rd_seq.push_back(int'(mif.rd_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] golden(input int z);
    logic [24:0] cur, prv, o;
    int          x, y, pc, pp;
    cur = mem_in[z];
    prv = mem_in[(z + 63) % 64];
    for (int i = 0; i < 25; i++) begin
      x  = (24 - i) % 5;
      y  = (24 - i) / 5;
      pc = 0;
      pp = 0;
      for (int r = 0; r < 5; r++) begin
        pc = pc ^ int'(cur[24 - (((x + 4) % 5) + 5 * r)]);
        pp = pp ^ int'(prv[24 - (((x + 1) % 5) + 5 * r)]);
      end
      o[i] = cur[24 - (x + 5 * y)] ^ pc[0] ^ pp[0];
    end
    return o;
  endfunction

  task automatic clear_logs();
    wr_count = 0; done_count = 0; first_wr_edge = 0; last_wr_edge = 0; done_edge = 0;
    order_ok = 1'b1;
    rd_seq.delete();
    for (int i = 0; i < 64; i++) out_mem[i] = 25'h1FFFFFF;
  endtask

  // One pass; with poke set, start is re-driven mid-RUN and during the DONE cycle.
  task automatic run_pass(input bit poke);
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    start_edge = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (poke && (i == 30 || done)) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_pass_shape(input string tag);
    check({tag, "_wr_count"}, wr_count, 64);
    check({tag, "_order"}, {31'd0, order_ok}, 1);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_first_wr"}, first_wr_edge - start_edge, 3);
    check({tag, "_last_wr"}, last_wr_edge - start_edge, 66);
    check({tag, "_done_edge"}, done_edge - start_edge, 67);
    check({tag, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  task automatic check_against_golden(input string tag);
    for (int z = 0; z < 64; z++) check($sformatf("%s_z%0d", tag, z), 32'(out_mem[z]), 32'(golden(z)));
  endtask

  initial begin
    int  nz;
    bit  seq_ok;
    int  wr_at_rst;
    start = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) mem_in[i] = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    check("rst_rd_en", {31'd0, mif.rd_en}, 0);
    check("rst_rd_addr", 32'(mif.rd_addr), 0);
    check("rst_wr_en", {31'd0, mif.wr_en}, 0);
    check("rst_wr_addr", 32'(mif.wr_addr), 0);
    check("rst_wr_data", 32'(mif.wr_data), 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero state
    run_pass(1'b0);
    check_pass_shape("zero");
    nz = 0;
    for (int z = 0; z < 64; z++) if (out_mem[z] != 25'h0) nz++;
    check("zero_nonzero_slices", nz, 0);

    // Single bit (x=1,y=0) in slice 63
    mem_in[63] = 25'h0800000;
    run_pass(1'b0);
    check("s63_addr0", 32'(out_mem[0]), 32'h1084210);
    check("s63_addr63", 32'(out_mem[63]), 32'h0C21084);
    nz = 0;
    for (int z = 1; z < 63; z++) if (out_mem[z] != 25'h0) nz++;
    check("s63_others", nz, 0);
    mem_in[63] = '0;

    // Single bit (x=0,y=0) in slice 5
    mem_in[5] = 25'h1000000;
    run_pass(1'b0);
    check("s5_addr5", 32'(out_mem[5]), 32'h1842108);
    check("s5_addr6", 32'(out_mem[6]), 32'h0108421);
    nz = 0;
    for (int z = 0; z < 64; z++) if (z != 5 && z != 6 && out_mem[z] != 25'h0) nz++;
    check("s5_others", nz, 0);

    // Random state vs golden model, plus read address sequence 63,0..63
    for (int i = 0; i < 64; i++) mem_in[i] = 25'($urandom());
    run_pass(1'b0);
    check_pass_shape("rand");
    check_against_golden("rand");
    check("rand_rd_count", rd_seq.size(), 65);
    seq_ok = (rd_seq.size() == 65);
    if (seq_ok) begin
      if (rd_seq[0] != 63) seq_ok = 1'b0;
      for (int i = 1; i < 65; i++) if (rd_seq[i] != i - 1) seq_ok = 1'b0;
    end
    check("rand_rd_seq", {31'd0, seq_ok}, 1);

    // start during RUN and in DONE must be ignored
    for (int i = 0; i < 64; i++) mem_in[i] = 25'($urandom());
    run_pass(1'b1);
    check_pass_shape("poke");
    check_against_golden("poke");

    // Reset asserted at RUN z=20
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mif.wr_en && mif.wr_addr == 6'd20) break;
      @(negedge clk);
    end
    check("abort_reached_z20", 32'(mif.wr_addr), 20);
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", {31'd0, mif.wr_en}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rd_en", {31'd0, mif.rd_en}, 0);
    check("abort_done", {31'd0, done}, 0);
    wr_at_rst = wr_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_more_writes", wr_count - wr_at_rst, 0);
    check("abort_no_done", done_count, 0);
    check("abort_idle_busy", {31'd0, busy}, 0);

    for (int i = 0; i < 64; i++) mem_in[i] = 25'($urandom());
    run_pass(1'b0);
    check_pass_shape("after_abort");
    check_against_golden("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
